// File: rtl/sourcea_arb.sv
// Round-robin arbiter between writeback (Put) and miss (Get) requests feeding SourceA,
// with a single registered output entry and an outstanding-request throttle.
`ifndef SET_BITS
`define SET_BITS 6
`endif
`ifndef OP_BITS
`define OP_BITS 3
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef SOURCE_BITS
`define SOURCE_BITS 4
`endif
`ifndef TAG_BITS
`define TAG_BITS 20
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef DATA_BITS
`define DATA_BITS 64
`endif
`ifndef MASK_BITS
`define MASK_BITS 8
`endif

module sourcea_arb #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned REQ_W           = `SET_BITS + `OP_BITS + `SIZE_BITS + `SOURCE_BITS +
                                           `TAG_BITS + `OFFSET_BITS + `DATA_BITS + `MASK_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_req_valid_i,
  output logic             wb_req_ready_o,
  input  logic [REQ_W-1:0] wb_req_bits_i,
  input  logic             mi_req_valid_i,
  output logic             mi_req_ready_o,
  input  logic [REQ_W-1:0] mi_req_bits_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [REQ_W-1:0] out_bits_o,
  input  logic             d_resp_fire_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             underflow_err_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  logic             out_valid_q, out_valid_d;
  logic [REQ_W-1:0] out_bits_q, out_bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             err_q, err_d;
  logic             slot_free, can_grant, grant_wb, grant_mi, grant;

  // The counter check uses the registered count, so a same-cycle response never unblocks.
  always_comb begin
    slot_free = !out_valid_q || out_ready_i;
    can_grant = rst_n && slot_free && (cnt_q < MaxCnt);
    grant_wb  = can_grant && wb_req_valid_i && (!mi_req_valid_i || !ptr_q);
    grant_mi  = can_grant && mi_req_valid_i && (!wb_req_valid_i || ptr_q);
    grant     = grant_wb || grant_mi;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_bits_d  = grant_wb ? wb_req_bits_i : mi_req_bits_i;
      ptr_d       = grant_wb;  // point at the side that lost
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (grant && !d_resp_fire_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!grant && d_resp_fire_i) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign wb_req_ready_o  = grant_wb;
  assign mi_req_ready_o  = grant_mi;
  assign out_valid_o     = out_valid_q;
  assign out_bits_o      = out_bits_q;
  assign outstanding_o   = cnt_q;
  assign underflow_err_o = err_q;

endmodule
